cfg_chain_loader: RTL

Bit-serial configuration loader that sits directly upstream of a daisy-chain of mode-manager configuration cells (e.g. mult_chain_stream_mode_manager_small instances linked output-to-input). It accepts configuration words over a valid/ready stream and serialises them onto the chain's configuration_input/configuration_enable pair. In the same pass it captures the bits falling out of the chain tail (configuration_output) and returns them as packed readback words, so the previous configuration can be verified.

---
 rtl/cfg_chain_pkg.sv | 18 +
 rtl/cfg_bit_packer.sv | 59 +++++
 rtl/cfg_chain_loader.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cfg_chain_pkg.sv
// Shared types and sizing helpers for the configuration chain loader.
package cfg_chain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_CHAIN_LEN = 6;
    localparam int DEF_WORD_W    = 8;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/cfg_bit_packer.sv
// Collects chain-tail bits LSB-first and hands them out as words through a
// single valid/ready output register.
module cfg_bit_packer
    import cfg_chain_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              bit_last,
    output logic              blocked,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    input  logic              rb_ready
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] acc_next;
    logic [CNT_W-1:0]  cnt;
    logic              completing;

    assign completing = bit_last || (cnt == CNT_W'(WORD_W - 1));
    // A completing bit needs the output register free (or freed this cycle).
    assign blocked    = completing && rb_valid && !rb_ready;
    assign acc_next   = acc | (WORD_W'(bit_in) << cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            cnt      <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            if (rb_valid && rb_ready) begin
                rb_valid <= 1'b0;
            end
            if (clear) begin
                acc <= '0;
                cnt <= '0;
            end else if (bit_valid) begin
                if (completing) begin
                    rb_data  <= acc_next;
                    rb_valid <= 1'b1;
                    acc      <= '0;
                    cnt      <= '0;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/cfg_chain_loader.sv
// Serialises configuration words onto a daisy-chain of config cells while
// capturing the bits shifted out of the chain tail as readback words.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting words and shifting bits into the chain
// FLUSH | all bits shifted, waiting for the final readback word to drain
// DONE  | one-cycle completion pulse
module cfg_chain_loader
    import cfg_chain_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int WORD_W    = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    input  logic              rb_ready,
    output logic              cfg_chain_in,
    output logic              cfg_chain_en,
    input  logic              cfg_chain_out
);

    localparam int NW          = ceil_div(CHAIN_LEN, WORD_W);
    localparam int LAST_BITS   = CHAIN_LEN - (NW - 1) * WORD_W;
    localparam int SHIFT_CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int BIT_CNT_W   = $clog2(WORD_W + 1);
    localparam int WORD_CNT_W  = $clog2(NW + 1);

    state_t                 state;
    state_t                 next_state;
    logic [WORD_W-1:0]      buf_data;
    logic [BIT_CNT_W-1:0]   buf_cnt;
    logic [SHIFT_CNT_W-1:0] shift_cnt;
    logic [WORD_CNT_W-1:0]  word_cnt;
    logic                   start_acc;
    logic                   accept;
    logic                   shift_en;
    logic                   last_shift;
    logic                   pk_blocked;

    assign start_acc  = (state == IDLE) && start;
    assign accept     = s_valid && s_ready;
    assign last_shift = (shift_cnt == SHIFT_CNT_W'(CHAIN_LEN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    if (shift_en && last_shift) next_state = FLUSH;
            FLUSH:   if (rb_valid && rb_ready) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        shift_en = 1'b0;
        s_ready  = 1'b0;
        case (state)
            LOAD: begin
                busy     = 1'b1;
                shift_en = (buf_cnt != '0)
                        && (shift_cnt < SHIFT_CNT_W'(CHAIN_LEN))
                        && !pk_blocked;
                // Refill while the last buffered bit leaves so words stream without bubbles.
                s_ready  = ((buf_cnt == '0) || ((buf_cnt == BIT_CNT_W'(1)) && shift_en))
                        && (word_cnt < WORD_CNT_W'(NW));
            end
            FLUSH:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_data  <= '0;
            buf_cnt   <= '0;
            shift_cnt <= '0;
            word_cnt  <= '0;
        end else if (start_acc) begin
            buf_data  <= '0;
            buf_cnt   <= '0;
            shift_cnt <= '0;
            word_cnt  <= '0;
        end else begin
            if (accept) begin
                buf_data <= s_data;
                buf_cnt  <= (word_cnt == WORD_CNT_W'(NW - 1)) ? BIT_CNT_W'(LAST_BITS)
                                                              : BIT_CNT_W'(WORD_W);
                word_cnt <= word_cnt + WORD_CNT_W'(1);
            end else if (shift_en) begin
                buf_data <= buf_data >> 1;
                buf_cnt  <= buf_cnt - BIT_CNT_W'(1);
            end
            if (shift_en) begin
                shift_cnt <= shift_cnt + SHIFT_CNT_W'(1);
            end
        end
    end

    assign cfg_chain_en = shift_en;
    assign cfg_chain_in = shift_en & buf_data[0];

    cfg_bit_packer #(
        .WORD_W(WORD_W)
    ) u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_acc),
        .bit_valid(shift_en),
        .bit_in   (cfg_chain_out),
        .bit_last (last_shift),
        .blocked  (pk_blocked),
        .rb_data  (rb_data),
        .rb_valid (rb_valid),
        .rb_ready (rb_ready)
    );

endmodule
